// File: rtl/mem_io_responder_pkg.sv
// Shared address-map constants and read-mux selector type for the proc-bus responder.
package mem_io_responder_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned REGION_W = 4;

  localparam logic [REGION_W-1:0] REG_RAM = 4'h0;
  localparam logic [REGION_W-1:0] REG_LED = 4'h1;
  localparam logic [REGION_W-1:0] REG_SW  = 4'h3;
  localparam logic [REGION_W-1:0] REG_TMR = 4'h4;

  localparam logic TMR_CNT  = 1'b0;
  localparam logic TMR_STAT = 1'b1;

  // Which source drives DIN for the access sampled on the previous edge
  typedef enum logic [1:0] {
    SEL_ZERO = 2'd0,
    SEL_RAM  = 2'd1,
    SEL_REG  = 2'd2
  } din_sel_e;

endpackage

// File: rtl/mem_io_responder_if.sv
// Proc-side memory bus: address, write data and strobe out of the proc, read data back.
interface mem_io_responder_if;
  import mem_io_responder_pkg::*;

  logic [DATA_W-1:0] ADDR;
  logic [DATA_W-1:0] DOUT;
  logic              W;
  logic [DATA_W-1:0] DIN;

  modport master (output ADDR, output DOUT, output W, input DIN);
  modport slave  (input ADDR, input DOUT, input W, output DIN);
endinterface

// File: rtl/mem_io_responder_ram_sync.sv
// Single-port synchronous RAM, registered read, read-before-write; maps onto block RAM.
module mem_io_responder_ram_sync #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 16
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [DW-1:0] mem_q [DEPTH];

  // Read returns the pre-write contents when the same word is written this edge
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/mem_io_responder.sv
// Memory-side responder for the proc bus: RAM, LED register, synchronised switches and
// an auto-reloading down-count timer, all answering reads with one cycle of latency.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int unsigned AW   = 8,
  parameter int unsigned NLED = 10,
  parameter int unsigned NSW  = 10
) (
  input  logic                Clock,
  input  logic                Resetn,
  mem_io_responder_if.slave   bus,
  input  logic [NSW-1:0]      SW,
  output logic [NLED-1:0]     LEDR,
  output logic                TIRQ
);

  logic [REGION_W-1:0] region_c;
  logic                ram_we_c;
  logic                tmr_wr_c;
  logic                expire_c;
  logic [DATA_W-1:0]   ram_rdata;
  logic                unused_addr_bits;

  logic [NLED-1:0]   led_q, led_d;
  logic [NSW-1:0]    sw_meta_q, sw_meta_d;
  logic [NSW-1:0]    sw_sync_q, sw_sync_d;
  logic [DATA_W-1:0] count_q, count_d;
  logic [DATA_W-1:0] reload_q, reload_d;
  logic              running_q, running_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] reg_rdata_q, reg_rdata_d;
  din_sel_e          din_sel_q, din_sel_d;

  assign region_c         = bus.ADDR[DATA_W-1:DATA_W-REGION_W];
  assign ram_we_c         = bus.W && Resetn && (region_c == REG_RAM);
  assign tmr_wr_c         = bus.W && (region_c == REG_TMR);
  assign expire_c         = running_q && (count_q == DATA_W'(1));
  assign unused_addr_bits = ^bus.ADDR[DATA_W-REGION_W-1:AW];

  mem_io_responder_ram_sync #(
    .AW (AW),
    .DW (DATA_W)
  ) u_ram (
    .clk_i   (Clock),
    .we_i    (ram_we_c),
    .addr_i  (bus.ADDR[AW-1:0]),
    .wdata_i (bus.DOUT),
    .rdata_o (ram_rdata)
  );

  // Decode, peripheral next state and read capture (reads see pre-write values)
  always_comb begin
    led_d       = led_q;
    sw_meta_d   = SW;
    sw_sync_d   = sw_meta_q;
    count_d     = count_q;
    reload_d    = reload_q;
    running_d   = running_q;
    done_d      = done_q;
    reg_rdata_d = '0;
    din_sel_d   = SEL_ZERO;

    unique case (region_c)
      REG_RAM: din_sel_d = SEL_RAM;
      REG_LED: begin
        din_sel_d   = SEL_REG;
        reg_rdata_d = DATA_W'(led_q);
      end
      REG_SW: begin
        din_sel_d   = SEL_REG;
        reg_rdata_d = DATA_W'(sw_sync_q);
      end
      REG_TMR: begin
        din_sel_d   = SEL_REG;
        reg_rdata_d = (bus.ADDR[0] == TMR_STAT) ? {14'b0, running_q, done_q} : count_q;
      end
      default: din_sel_d = SEL_ZERO;
    endcase

    if (bus.W && (region_c == REG_LED)) led_d = bus.DOUT[NLED-1:0];

    if (running_q) count_d = expire_c ? reload_q : count_q - DATA_W'(1);

    // Expiry is applied after the clear so a coincident set wins
    if (tmr_wr_c && (bus.ADDR[0] == TMR_STAT)) done_d = 1'b0;
    if (expire_c) done_d = 1'b1;

    if (tmr_wr_c && (bus.ADDR[0] == TMR_CNT)) begin
      reload_d  = bus.DOUT;
      count_d   = bus.DOUT;
      running_d = (bus.DOUT != '0);
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      led_q       <= '0;
      sw_meta_q   <= '0;
      sw_sync_q   <= '0;
      count_q     <= '0;
      reload_q    <= '0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      reg_rdata_q <= '0;
      din_sel_q   <= SEL_ZERO;
    end else begin
      led_q       <= led_d;
      sw_meta_q   <= sw_meta_d;
      sw_sync_q   <= sw_sync_d;
      count_q     <= count_d;
      reload_q    <= reload_d;
      running_q   <= running_d;
      done_q      <= done_d;
      reg_rdata_q <= reg_rdata_d;
      din_sel_q   <= din_sel_d;
    end
  end

  // Selection was registered with the RAM read, so DIN depends on flops only
  always_comb begin
    unique case (din_sel_q)
      SEL_RAM: bus.DIN = ram_rdata;
      SEL_REG: bus.DIN = reg_rdata_q;
      default: bus.DIN = '0;
    endcase
  end

  assign LEDR = led_q;
  assign TIRQ = done_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: directed scenarios then random traffic against a
// cycle-indexed reference model of the address map, switches and timer.
module tb_mem_io_responder;

  logic        Clock;
  logic        Resetn;
  logic [9:0]  SW;
  logic [9:0]  LEDR;
  logic        TIRQ;

  mem_io_responder_if bus ();

  mem_io_responder #(.AW(8), .NLED(10), .NSW(10)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus),
    .SW     (SW),
    .LEDR   (LEDR),
    .TIRQ   (TIRQ)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  // Reference state: p is the posedge index; timer is described by load edge and period
  logic [15:0] ram_m [256];
  logic [9:0]  sw_hist [4];
  logic [9:0]  led_m = '0;
  logic [9:0]  sw_v = '0;
  logic [15:0] exp_din = '0;
  logic        done_m = 1'b0;
  logic        run_m = 1'b0;
  int          p = 0;
  int          last_rst = 0;
  int          t_load = 0;
  int          per = 1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h (edge %0d)", tag, obs, expv, p);
    end
  endtask

  function automatic logic [15:0] count_before(input int edge_n);
    if (!run_m) return 16'h0000;
    return 16'(per - ((edge_n - 1 - t_load) % per));
  endfunction

  task automatic model(input logic rn, input logic w, input logic [15:0] a,
                       input logic [15:0] d, input logic [9:0] swin);
    logic expire;
    p++;
    if (!rn) begin
      exp_din  = '0;
      led_m    = '0;
      run_m    = 1'b0;
      done_m   = 1'b0;
      last_rst = p;
    end else begin
      case (a[15:12])
        4'h0:    exp_din = ram_m[a[7:0]];
        4'h1:    exp_din = 16'(led_m);
        4'h3:    exp_din = (p - 2 > last_rst) ? 16'(sw_hist[(p - 2) % 4]) : 16'h0000;
        4'h4:    exp_din = a[0] ? {14'b0, run_m, done_m} : count_before(p);
        default: exp_din = 16'h0000;
      endcase
      expire = run_m && ((p - t_load) % per == 0);
      if (w) begin
        case (a[15:12])
          4'h0: ram_m[a[7:0]] = d;
          4'h1: led_m = d[9:0];
          4'h4: begin
            if (a[0]) done_m = 1'b0;
            else if (d == 16'h0000) run_m = 1'b0;
            else begin
              run_m  = 1'b1;
              t_load = p;
              per    = int'(d);
            end
          end
          default: ;
        endcase
      end
      if (expire) done_m = 1'b1;
    end
    sw_hist[p % 4] = swin;
  endtask

  task automatic cycle(input logic rn, input logic w, input logic [15:0] a, input logic [15:0] d);
    Resetn   = rn;
    bus.W    = w;
    bus.ADDR = a;
    bus.DOUT = d;
    SW       = sw_v;
    @(posedge Clock);
    model(rn, w, a, d, sw_v);
    #1;
    chk("din", bus.DIN, exp_din);
    chk("ledr", 16'(LEDR), 16'(led_m));
    chk("tirq", 16'(TIRQ), 16'(done_m));
  endtask

  initial begin
    logic [15:0] a, d;
    logic        w, rn;
    int unsigned r;

    cycle(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("reset_din", bus.DIN, 16'h0000);
    chk("reset_tirq", 16'(TIRQ), 16'h0000);
    cycle(1'b0, 1'b1, 16'h4000, 16'h0002);
    chk("reset_ignores_w", 16'(TIRQ), 16'h0000);

    for (int i = 0; i < 256; i++) cycle(1'b1, 1'b1, 16'(i), 16'($urandom));

    // Write then read back
    cycle(1'b1, 1'b1, 16'h0005, 16'hBEEF);
    cycle(1'b1, 1'b0, 16'h0005, 16'h0000);
    chk("t1_readback", bus.DIN, 16'hBEEF);

    // Read-during-write returns old data
    cycle(1'b1, 1'b1, 16'h0005, 16'h1111);
    cycle(1'b1, 1'b1, 16'h0005, 16'h2222);
    chk("t2_rdw_old", bus.DIN, 16'h1111);
    cycle(1'b1, 1'b0, 16'h0005, 16'h0000);
    chk("t2_rdw_new", bus.DIN, 16'h2222);

    // Aliasing of upper RAM index bits
    cycle(1'b1, 1'b1, 16'h0F07, 16'h5A5A);
    cycle(1'b1, 1'b0, 16'h0007, 16'h0000);
    chk("alias", bus.DIN, 16'h5A5A);

    // LED register and unmapped region
    cycle(1'b1, 1'b1, 16'h1000, 16'hFFFF);
    chk("t3_ledr", 16'(LEDR), 16'h03FF);
    cycle(1'b1, 1'b0, 16'h1000, 16'h0000);
    chk("t3_led_read", bus.DIN, 16'h03FF);
    cycle(1'b1, 1'b0, 16'h7000, 16'h0000);
    chk("t3_unmapped", bus.DIN, 16'h0000);

    // Switch synchroniser latency
    sw_v = 10'h155;
    cycle(1'b1, 1'b0, 16'h3000, 16'h0000);
    chk("t4_sw_old", bus.DIN, 16'h0000);
    cycle(1'b1, 1'b0, 16'h0000, 16'h0000);
    cycle(1'b1, 1'b0, 16'h3000, 16'h0000);
    chk("t4_sw_new", bus.DIN, 16'h0155);

    // Timer period 3, clear coinciding with expiry, then a real clear
    cycle(1'b1, 1'b1, 16'h4000, 16'h0003);
    cycle(1'b1, 1'b0, 16'h4000, 16'h0000);
    chk("t5_cnt3", bus.DIN, 16'h0003);
    cycle(1'b1, 1'b0, 16'h4000, 16'h0000);
    chk("t5_cnt2", bus.DIN, 16'h0002);
    cycle(1'b1, 1'b1, 16'h4001, 16'h0000);
    chk("t5_set_wins", 16'(TIRQ), 16'h0001);
    cycle(1'b1, 1'b0, 16'h4000, 16'h0000);
    chk("t5_reload", bus.DIN, 16'h0003);
    cycle(1'b1, 1'b1, 16'h4001, 16'h0000);
    chk("t5_clear", 16'(TIRQ), 16'h0000);

    // Reset pulse while timer runs
    cycle(1'b1, 1'b1, 16'h1000, 16'h02AA);
    chk("t6_led", 16'(LEDR), 16'h02AA);
    cycle(1'b0, 1'b1, 16'h1000, 16'hFFFF);
    chk("t6_ledr0", 16'(LEDR), 16'h0000);
    chk("t6_din0", bus.DIN, 16'h0000);
    cycle(1'b1, 1'b0, 16'h4001, 16'h0000);
    chk("t6_status0", bus.DIN, 16'h0000);
    cycle(1'b1, 1'b0, 16'h0005, 16'h0000);
    chk("t6_ram_kept", bus.DIN, 16'h2222);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      r  = $urandom_range(0, 9);
      d  = 16'($urandom);
      w  = 1'($urandom_range(0, 1));
      rn = ($urandom_range(0, 299) != 0);
      if (r <= 3)      a = {4'h0, 12'($urandom)};
      else if (r == 4) a = 16'h1000 | 16'($urandom_range(0, 15));
      else if (r == 5) a = 16'h3000;
      else if (r <= 7) begin
        a = 16'h4000 | 16'($urandom_range(0, 1));
        w = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 7) != 0) d = 16'($urandom_range(0, 6));
      end else begin
        a = {4'($urandom_range(5, 15)), 12'($urandom)};
        if ($urandom_range(0, 1) == 0) a[15:12] = 4'h2;
      end
      if ($urandom_range(0, 6) == 0) sw_v = 10'($urandom);
      cycle(rn, w, a, d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
